// File: rtl/key_bounce_gen.sv
// ---------------------------------------------------------------------------
// key_bounce_gen
//
// Emulates a mechanically bouncing, active-low push button. It drives the key
// input of a debouncer so that on-board self-test and loopback benches can
// exercise the debounce path without a physical button. Each accepted press
// makes a falling bounce burst, a stable low hold and a rising bounce burst.
// The length of each bounce segment comes from a free-running 16-bit Galois
// LFSR, so a given SEED and press cycle always give the same waveform.
//
// Parameters:
//   BOUNCE_EDGES : glitch pairs per bounce phase (0 = clean press)
//   SEG_W        : segment field width; a segment lasts lfsr[SEG_W-1:0]+1 cycles
//   HOLD_CYCLES  : stable-low cycles after the last falling edge (>= 1)
//   CNT_W        : hold counter width (HOLD_CYCLES < 2**CNT_W)
//   SEED         : LFSR reset value (nonzero)
//
// Ports:
//   clk       : system clock
//   rst       : synchronous reset, active-high
//   press_req : single-cycle press request, only sampled while idle
//   key_n     : emulated key line, active-low, idles high
//   busy      : high while a press sequence is in progress
//   done      : one-cycle pulse in the cycle key_n reaches its final high level
// ---------------------------------------------------------------------------
module key_bounce_gen #(
    parameter int unsigned BOUNCE_EDGES = 3,
    parameter int unsigned SEG_W        = 4,
    parameter int unsigned HOLD_CYCLES  = 240000,
    parameter int unsigned CNT_W        = 20,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic press_req,
    output logic key_n,
    output logic busy,
    output logic done
);

    // One spare bit so the toggle counter is at least 1 bit wide for a clean press.
    localparam int unsigned TOG_W = $clog2(2 * BOUNCE_EDGES + 2);

    // The FALL->HOLD step itself is one of the low cycles, and so is the
    // cycle that sees the counter at 0; the load value removes both.
    localparam int unsigned HOLD_LOAD = (HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0;

    localparam logic [15:0]      LFSR_MASK = 16'hB400;
    localparam logic [TOG_W-1:0] TOG_LOAD  = TOG_W'(2 * BOUNCE_EDGES);
    localparam logic [TOG_W-1:0] TOG_ONE   = TOG_W'(1);
    localparam logic [SEG_W:0]   SEG_ONE   = (SEG_W + 1)'(1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_LOAD);
    localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FALL,
        HOLD,
        RISE
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [TOG_W-1:0] tog_cnt;
    logic [SEG_W:0]   seg_cnt;   // one extra bit so 2**SEG_W fits
    logic [CNT_W-1:0] hold_cnt;
    logic [SEG_W:0]   seg_load;
    logic             seg_expired;

    assign seg_load    = {1'b0, lfsr[SEG_W-1:0]} + SEG_ONE;
    // A segment loaded with N expires N cycles after the edge that loaded it.
    assign seg_expired = (seg_cnt <= SEG_ONE);

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= SEED;
            tog_cnt  <= '0;
            seg_cnt  <= '0;
            hold_cnt <= '0;
            key_n    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Galois step, right-shifting; advances in every state.
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (press_req) begin
                        key_n   <= 1'b0;
                        busy    <= 1'b1;
                        tog_cnt <= TOG_LOAD;
                        seg_cnt <= seg_load;
                        state   <= FALL;
                    end
                end

                FALL: begin
                    if (tog_cnt == '0) begin
                        if (HOLD_CYCLES < 2) begin
                            // The low hold has already elapsed: rise right away.
                            key_n <= 1'b1;
                            if (BOUNCE_EDGES == 0) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                tog_cnt <= TOG_LOAD;
                                seg_cnt <= seg_load;
                                state   <= RISE;
                            end
                        end else begin
                            hold_cnt <= HOLD_INIT;
                            state    <= HOLD;
                        end
                    end else if (seg_expired) begin
                        key_n   <= ~key_n;
                        tog_cnt <= tog_cnt - TOG_ONE;
                        seg_cnt <= seg_load;
                    end else begin
                        seg_cnt <= seg_cnt - SEG_ONE;
                    end
                end

                HOLD: begin
                    if (hold_cnt == '0) begin
                        key_n <= 1'b1;
                        if (BOUNCE_EDGES == 0) begin
                            // Without bounce the rising edge is also the final level.
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            tog_cnt <= TOG_LOAD;
                            seg_cnt <= seg_load;
                            state   <= RISE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end

                RISE: begin
                    if (seg_expired) begin
                        key_n   <= ~key_n;
                        tog_cnt <= tog_cnt - TOG_ONE;
                        seg_cnt <= seg_load;
                        // Even toggle count: the last toggle lands on 1.
                        if (tog_cnt == TOG_ONE) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        seg_cnt <= seg_cnt - SEG_ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// ---------------------------------------------------------------------------
// tb_key_bounce_gen
//
// Two instances share clk/rst: dut_clean (no bounce, 5-cycle hold) and
// dut_bounce (2 glitch pairs, 2-bit segments, 20-cycle hold). Edge times of
// the bouncing key line are predicted from an independent LFSR timeline
// model and compared cycle-exactly.
// ---------------------------------------------------------------------------
module tb_key_bounce_gen;

    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          B_EDGES = 2;
    localparam int          B_SEG_W = 2;
    localparam int          B_HOLD  = 20;
    localparam int          C_HOLD  = 5;

    logic clk = 1'b0;
    logic rst;
    logic press_c;
    logic press_b;
    logic key_c, busy_c, done_c;
    logic key_b, busy_b, done_b;

    int checks  = 0;
    int errors  = 0;
    int edge_no = 0;
    bit mon_en  = 1'b0;
    logic prev_b = 1'b1;

    int b_edges[$];
    int b_dones[$];
    int c_dones[$];
    int exp_edges[$];
    int exp_done[$];

    always #5 clk = ~clk;

    key_bounce_gen #(
        .BOUNCE_EDGES(0),
        .SEG_W       (4),
        .HOLD_CYCLES (C_HOLD),
        .CNT_W       (8),
        .SEED        (SEED)
    ) dut_clean (
        .clk      (clk),
        .rst      (rst),
        .press_req(press_c),
        .key_n    (key_c),
        .busy     (busy_c),
        .done     (done_c)
    );

    key_bounce_gen #(
        .BOUNCE_EDGES(B_EDGES),
        .SEG_W       (B_SEG_W),
        .HOLD_CYCLES (B_HOLD),
        .CNT_W       (8),
        .SEED        (SEED)
    ) dut_bounce (
        .clk      (clk),
        .rst      (rst),
        .press_req(press_b),
        .key_n    (key_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    // Number every rising edge; log key_b changes and done pulses against
    // the edge that produced them, sampled 2 time units after the edge.
    always @(posedge clk) begin
        edge_no++;
        #2;
        if (mon_en && key_b !== prev_b) b_edges.push_back(edge_no);
        prev_b = key_b;
        if (mon_en && done_b === 1'b1) b_dones.push_back(edge_no);
        if (mon_en && done_c === 1'b1) c_dones.push_back(edge_no);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Segment length loaded at edge t when the last reset edge was r:
    // the register holds SEED at edge r+1 and steps once per edge after that.
    function automatic int seg_len(input int r, input int t);
        logic [15:0] v;
        v = SEED;
        for (int i = 1; i < t - r; i++) v = lfsr_step(v);
        return int'(v[B_SEG_W-1:0]) + 1;
    endfunction

    // Append the predicted edge list and done edge of one press accepted at edge p.
    task automatic model_seq(input int r, input int p);
        int t;
        t = p;
        exp_edges.push_back(t);
        for (int i = 0; i < 2 * B_EDGES; i++) begin
            t += seg_len(r, t);
            exp_edges.push_back(t);
        end
        t += B_HOLD;
        exp_edges.push_back(t);
        for (int i = 0; i < 2 * B_EDGES; i++) begin
            t += seg_len(r, t);
            exp_edges.push_back(t);
        end
        exp_done.push_back(t);
    endtask

    task automatic wait_done_b(input string tag, input int want);
        int n;
        n = 0;
        while (b_dones.size() < want && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, b_dones.size() >= want, 1);
    endtask

    task automatic compare_run(input string tag, input int e_base, input int d_base);
        check({tag, "_edge_count"}, b_edges.size() - e_base, exp_edges.size());
        foreach (exp_edges[i])
            if (e_base + i < b_edges.size())
                check($sformatf("%s_edge%0d", tag, i), b_edges[e_base + i], exp_edges[i]);
        check({tag, "_done_count"}, b_dones.size() - d_base, exp_done.size());
        foreach (exp_done[i])
            if (d_base + i < b_dones.size())
                check($sformatf("%s_done%0d", tag, i), b_dones[d_base + i], exp_done[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r_edge;
        int p;
        int e_base;
        int d_base;
        int target;
        int p_next;
        int ab_off[5];

        rst     = 1'b1;
        press_c = 1'b0;
        press_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_key_c", key_c, 1);
        check("rst_busy_c", busy_c, 0);
        check("rst_done_c", done_c, 0);
        check("rst_key_b", key_b, 1);
        check("rst_busy_b", busy_b, 0);
        check("rst_done_b", done_b, 0);
        rst    = 1'b0;
        r_edge = edge_no;
        mon_en = 1'b1;

        // Clean press, request sampled at reset edge + 10
        repeat (9) @(negedge clk);
        press_c = 1'b1;
        #1;
        check("clean_no_comb_key", key_c, 1);
        check("clean_no_comb_busy", busy_c, 0);
        @(negedge clk);
        press_c = 1'b0;
        for (int i = 0; i <= C_HOLD + 1; i++) begin
            check($sformatf("clean_key_c%0d", i), key_c, (i < C_HOLD) ? 0 : 1);
            check($sformatf("clean_busy_c%0d", i), busy_c, (i < C_HOLD) ? 1 : 0);
            check($sformatf("clean_done_c%0d", i), done_c, (i == C_HOLD) ? 1 : 0);
            @(negedge clk);
        end
        check("clean_done_count", c_dones.size(), 1);

        // Bounce sequence against the LFSR timeline model
        e_base = b_edges.size();
        d_base = b_dones.size();
        exp_edges.delete();
        exp_done.delete();
        press_b = 1'b1;
        @(negedge clk);
        press_b = 1'b0;
        p = edge_no;
        model_seq(r_edge, p);
        wait_done_b("b1_done_timeout", d_base + 1);
        check("b1_done_key", key_b, 1);
        check("b1_done_busy", busy_b, 0);
        compare_run("b1", e_base, d_base);
        if (b_edges.size() >= e_base + 10) begin
            for (int k = 0; k < 9; k++) begin
                if (k != 4) begin
                    int d;
                    d = b_edges[e_base + k + 1] - b_edges[e_base + k];
                    check($sformatf("b1_spacing%0d_in_range", k), (d >= 1 && d <= 4), 1);
                end
            end
            check("b1_hold_len", b_edges[e_base + 5] - b_edges[e_base + 4], B_HOLD);
        end
        repeat (3) @(negedge clk);

        // press_req held high through a whole sequence and into its done cycle
        e_base = b_edges.size();
        d_base = b_dones.size();
        exp_edges.delete();
        exp_done.delete();
        press_b = 1'b1;
        @(negedge clk);
        p = edge_no;
        model_seq(r_edge, p);
        p_next = exp_done[0] + 1;
        wait_done_b("ign_done1_timeout", d_base + 1);
        @(negedge clk);
        press_b = 1'b0;
        check("ign_restart_key", key_b, 0);
        check("ign_restart_busy", busy_b, 1);
        model_seq(r_edge, p_next);
        wait_done_b("ign_done2_timeout", d_base + 2);
        repeat (40) @(negedge clk);
        compare_run("ign", e_base, d_base);

        // Reset during HOLD, then repeat a press at the same offset from reset
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        r_edge = edge_no;
        e_base = b_edges.size();
        d_base = b_dones.size();
        exp_edges.delete();
        exp_done.delete();
        repeat (4) @(negedge clk);
        press_b = 1'b1;
        @(negedge clk);
        press_b = 1'b0;
        p = edge_no;
        model_seq(r_edge, p);
        target = exp_edges[4] + 5;
        while (edge_no < target) @(negedge clk);
        check("abort_fall_edges", b_edges.size() - e_base, 5);
        for (int i = 0; i < 5; i++) begin
            ab_off[i] = (e_base + i < b_edges.size()) ? b_edges[e_base + i] - p : -1;
            check($sformatf("abort_edge%0d", i), ab_off[i], exp_edges[i] - p);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_key", key_b, 1);
        check("abort_busy", busy_b, 0);
        check("abort_done", done_b, 0);
        r_edge = edge_no;
        e_base = b_edges.size();
        exp_edges.delete();
        exp_done.delete();
        repeat (4) @(negedge clk);
        press_b = 1'b1;
        @(negedge clk);
        press_b = 1'b0;
        p = edge_no;
        model_seq(r_edge, p);
        wait_done_b("rerun_done_timeout", d_base + 1);
        repeat (10) @(negedge clk);
        compare_run("rerun", e_base, d_base);
        for (int i = 0; i < 5; i++)
            if (e_base + i < b_edges.size())
                check($sformatf("rerun_matches_abort%0d", i), b_edges[e_base + i] - p, ab_off[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
